// File: rtl/ststk_ctl_pkg.sv
// Status-stack controller shared types.
// FSM and request encodings, status word field layout.
package ststk_ctl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_POP  = 2'd2,
    S_RSTR = 2'd3
  } state_e;

  // Encoding value doubles as priority rank: 0 wins.
  typedef enum logic [1:0] {
    OP_IRQ_PUSH = 2'd0,
    OP_RTI_POP  = 2'd1,
    OP_INS_POP  = 2'd2,
    OP_INS_PUSH = 2'd3
  } op_e;

  localparam int NREQ = 4;

  localparam int ASTAT_W = 8;
  localparam int MSTAT_W = 7;
  localparam int IMASK_W = 10;
  localparam int STS_W = ASTAT_W + MSTAT_W + IMASK_W;

  localparam int ASTAT_LSB = 0;
  localparam int MSTAT_LSB = ASTAT_LSB + ASTAT_W;
  localparam int IMASK_LSB = MSTAT_LSB + MSTAT_W;

  function automatic logic is_push(op_e op);
    return (op == OP_IRQ_PUSH) ||
           (op == OP_INS_PUSH);
  endfunction

endpackage

// File: rtl/ststk_ctl_if.sv
// Request/grant bundle between controller and arbiter.
// req: level requests indexed by op_e; gnt/gnt_vld: winner.
interface ststk_ctl_if;
  import ststk_ctl_pkg::*;

  logic [NREQ-1:0] req;
  op_e             gnt;
  logic            gnt_vld;

  modport master (
    output req,
    input  gnt,
    input  gnt_vld
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_vld
  );

endinterface

// File: rtl/ststk_arb.sv
// Fixed-priority 4-request grant encoder.
// Ports: bus (slave) -- req in, gnt/gnt_vld out.
module ststk_arb
  import ststk_ctl_pkg::*;
(
  ststk_ctl_if.slave bus
);

  always_comb begin
    bus.gnt     = OP_IRQ_PUSH;
    bus.gnt_vld = |bus.req;
    if (bus.req[OP_IRQ_PUSH])
      bus.gnt = OP_IRQ_PUSH;
    else if (bus.req[OP_RTI_POP])
      bus.gnt = OP_RTI_POP;
    else if (bus.req[OP_INS_POP])
      bus.gnt = OP_INS_POP;
    else if (bus.req[OP_INS_PUSH])
      bus.gnt = OP_INS_PUSH;
  end

endmodule

// File: rtl/ststk_ctl.sv
// Status stack controller: saves/restores ASTAT/MSTAT/IMASK.
// Ports: 4 req/ack pairs, stack strobes+flags, restore, errors.
module ststk_ctl
  import ststk_ctl_pkg::*;
(
  input  logic               DSPCLK,
  input  logic               T_RST_,
  input  logic               IRQ_PUSH_REQ,
  input  logic               RTI_POP_REQ,
  input  logic               INS_PUSH_REQ,
  input  logic               INS_POP_REQ,
  output logic               IRQ_PUSH_ACK,
  output logic               RTI_POP_ACK,
  output logic               INS_PUSH_ACK,
  output logic               INS_POP_ACK,
  input  logic [ASTAT_W-1:0] ASTAT,
  input  logic [MSTAT_W-1:0] MSTAT,
  input  logic [IMASK_W-1:0] IMASK,
  input  logic               ST_full,
  input  logic               ST_empty,
  input  logic               ST_has1,
  input  logic [STS_W-1:0]   TopST,
  output logic [STS_W-1:0]   STin,
  output logic               PushST_EN,
  output logic               PopST_EN,
  output logic               STS_CKenb,
  output logic               RST_VLD,
  output logic [ASTAT_W-1:0] ASTAT_R,
  output logic [MSTAT_W-1:0] MSTAT_R,
  output logic [IMASK_W-1:0] IMASK_R,
  output logic               STK_OVF,
  output logic               STK_UNF,
  input  logic               ERR_CLR
);

  ststk_ctl_if arb_if ();

  assign arb_if.req = {
    INS_PUSH_REQ,
    INS_POP_REQ,
    RTI_POP_REQ,
    IRQ_PUSH_REQ
  };

  ststk_arb u_arb (
    .bus (arb_if)
  );

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [STS_W-1:0] rstr_q, rstr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [NREQ-1:0]  ack;
  logic             push_en;
  logic             pop_en;
  logic             rst_vld;
  logic [STS_W-1:0] stin;

  logic unused_has1;
  assign unused_has1 = ST_has1;

  always_ff @(posedge DSPCLK or negedge T_RST_) begin
    if (!T_RST_) begin
      state_q <= S_IDLE;
      op_q    <= OP_IRQ_PUSH;
      rstr_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rstr_q  <= rstr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rstr_d  = rstr_q;
    // Clear first; a set below overrides it.
    ovf_d   = ovf_q & ~ERR_CLR;
    unf_d   = unf_q & ~ERR_CLR;
    ack     = '0;
    push_en = 1'b0;
    pop_en  = 1'b0;
    rst_vld = 1'b0;
    stin    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_if.gnt_vld) begin
          op_d    = arb_if.gnt;
          state_d = is_push(arb_if.gnt)
                  ? S_PUSH : S_POP;
        end
      end
      S_PUSH: begin
        ack[op_q] = 1'b1;
        push_en   = ~ST_full;
        stin[ASTAT_LSB +: ASTAT_W] = ASTAT;
        stin[MSTAT_LSB +: MSTAT_W] = MSTAT;
        stin[IMASK_LSB +: IMASK_W] = IMASK;
        if (ST_full)
          ovf_d = 1'b1;
        state_d = S_IDLE;
      end
      S_POP: begin
        ack[op_q] = 1'b1;
        pop_en    = ~ST_empty;
        if (ST_empty) begin
          unf_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          rstr_d  = TopST;
          state_d = S_RSTR;
        end
      end
      S_RSTR: begin
        rst_vld = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign IRQ_PUSH_ACK = ack[OP_IRQ_PUSH];
  assign RTI_POP_ACK  = ack[OP_RTI_POP];
  assign INS_POP_ACK  = ack[OP_INS_POP];
  assign INS_PUSH_ACK = ack[OP_INS_PUSH];

  assign PushST_EN = push_en;
  assign PopST_EN  = pop_en;
  assign STin      = stin;
  assign RST_VLD   = rst_vld;

  assign STS_CKenb = ~((state_q == S_PUSH) ||
                       (state_q == S_POP));

  assign ASTAT_R = rstr_q[ASTAT_LSB +: ASTAT_W];
  assign MSTAT_R = rstr_q[MSTAT_LSB +: MSTAT_W];
  assign IMASK_R = rstr_q[IMASK_LSB +: IMASK_W];

  assign STK_OVF = ovf_q;
  assign STK_UNF = unf_q;

endmodule

// File: tb/tb_ststk_ctl.sv
// Scoreboard bench for ststk_ctl with a queue-based stack model.
// Stimulus predicts grant sequences; a monitor checks each ACK.
module tb_ststk_ctl;
  import ststk_ctl_pkg::*;

  localparam int DEPTH = 4;

  logic        DSPCLK = 1'b0;
  logic        T_RST_ = 1'b0;
  logic        IRQ_PUSH_ACK, RTI_POP_ACK;
  logic        INS_PUSH_ACK, INS_POP_ACK;
  logic [7:0]  ASTAT = '0;
  logic [6:0]  MSTAT = '0;
  logic [9:0]  IMASK = '0;
  logic        ST_full = 1'b0;
  logic        ST_empty = 1'b1;
  logic        ST_has1 = 1'b0;
  logic [24:0] TopST = '0;
  logic [24:0] STin;
  logic        PushST_EN, PopST_EN;
  logic        STS_CKenb, RST_VLD;
  logic [7:0]  ASTAT_R;
  logic [6:0]  MSTAT_R;
  logic [9:0]  IMASK_R;
  logic        STK_OVF, STK_UNF;
  logic        ERR_CLR = 1'b0;

  ststk_ctl_if bif ();

  ststk_ctl dut (
    .DSPCLK       (DSPCLK),
    .T_RST_       (T_RST_),
    .IRQ_PUSH_REQ (bif.req[0]),
    .RTI_POP_REQ  (bif.req[1]),
    .INS_PUSH_REQ (bif.req[3]),
    .INS_POP_REQ  (bif.req[2]),
    .IRQ_PUSH_ACK (IRQ_PUSH_ACK),
    .RTI_POP_ACK  (RTI_POP_ACK),
    .INS_PUSH_ACK (INS_PUSH_ACK),
    .INS_POP_ACK  (INS_POP_ACK),
    .ASTAT        (ASTAT),
    .MSTAT        (MSTAT),
    .IMASK        (IMASK),
    .ST_full      (ST_full),
    .ST_empty     (ST_empty),
    .ST_has1      (ST_has1),
    .TopST        (TopST),
    .STin         (STin),
    .PushST_EN    (PushST_EN),
    .PopST_EN     (PopST_EN),
    .STS_CKenb    (STS_CKenb),
    .RST_VLD      (RST_VLD),
    .ASTAT_R      (ASTAT_R),
    .MSTAT_R      (MSTAT_R),
    .IMASK_R      (IMASK_R),
    .STK_OVF      (STK_OVF),
    .STK_UNF      (STK_UNF),
    .ERR_CLR      (ERR_CLR)
  );

  initial forever #5 DSPCLK = ~DSPCLK;

  typedef struct packed {
    logic [3:0]  ack;
    logic        pe;
    logic        po;
    logic        rv;
    logic [24:0] stin;
    logic [24:0] top;
  } exp_t;

  exp_t        expq[$];
  logic [24:0] pred[$];
  logic [24:0] stk[$];
  int          ack_t[$];
  int          ack_cnt[4];
  int          need[4];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          ovf_m = 0;
  bit          unf_m = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [3:0] acks();
    return {INS_PUSH_ACK, INS_POP_ACK,
            RTI_POP_ACK, IRQ_PUSH_ACK};
  endfunction

  // Save request: status word is {IMASK, MSTAT, ASTAT}.
  task automatic add_push(input int i);
    exp_t e;
    e = '0;
    e.ack = 4'b0001 << i;
    e.stin = {IMASK, MSTAT, ASTAT};
    if (pred.size() < DEPTH) begin
      e.pe = 1'b1;
      pred.push_back(e.stin);
    end else begin
      ovf_m = 1'b1;
    end
    expq.push_back(e);
  endtask

  task automatic add_pop(input int i);
    exp_t e;
    e = '0;
    e.ack = 4'b0001 << i;
    if (pred.size() > 0) begin
      e.po = 1'b1;
      e.rv = 1'b1;
      e.top = pred.pop_back();
    end else begin
      unf_m = 1'b1;
    end
    expq.push_back(e);
  endtask

  initial forever begin
    @(posedge DSPCLK);
    cyc++;
  end

  // External stack: follows the strobes seen in each cycle.
  initial begin
    bit cp, cq, r;
    logic [24:0] cs;
    forever begin
      @(negedge DSPCLK);
      cp = PushST_EN;
      cq = PopST_EN;
      cs = STin;
      @(posedge DSPCLK);
      r = T_RST_;
      #1;
      if (r) begin
        if (cp && stk.size() < DEPTH)
          stk.push_back(cs);
        if (cq && stk.size() > 0)
          void'(stk.pop_back());
      end
      ST_full  = (stk.size() == DEPTH);
      ST_empty = (stk.size() == 0);
      ST_has1  = (stk.size() == 1);
      TopST    = (stk.size() > 0) ? stk[$] : '0;
    end
  end

  // Monitor.
  initial begin
    bit pend;
    logic [24:0] ptop;
    logic [3:0] a;
    exp_t cur;
    pend = 0;
    ptop = '0;
    forever begin
      @(negedge DSPCLK);
      if (!T_RST_) begin
        pend = 0;
      end else begin
        chk("push_pop_excl", PushST_EN & PopST_EN, 0);
        a = acks();
        if (a != 0) begin
          ack_t.push_back(cyc);
          for (int i = 0; i < 4; i++)
            ack_cnt[i] += int'(a[i]);
          if (pend) begin
            chk("rst_vld", RST_VLD, 1);
            pend = 0;
          end
          if (expq.size() == 0) begin
            chk("unexpected_ack", a, 0);
          end else begin
            cur = expq.pop_front();
            chk("ack", a, cur.ack);
            chk("push_en", PushST_EN, cur.pe);
            chk("pop_en", PopST_EN, cur.po);
            if (cur.ack[0] | cur.ack[3])
              chk("stin", STin, cur.stin);
            chk("ckenb_busy", STS_CKenb, 0);
            chk("rst_vld_busy", RST_VLD, 0);
            pend = cur.rv;
            ptop = cur.top;
          end
        end else begin
          chk("ckenb_idle", STS_CKenb, 1);
          if (pend) begin
            chk("rst_vld", RST_VLD, 1);
            chk("astat_r", ASTAT_R, ptop[7:0]);
            chk("mstat_r", MSTAT_R, ptop[14:8]);
            chk("imask_r", IMASK_R, ptop[24:15]);
            pend = 0;
          end else begin
            chk("rst_vld_quiet", RST_VLD, 0);
          end
        end
      end
    end
  end

  task automatic run_batch(input logic [3:0] mask);
    int left[4];
    int t0, n, hi;
    bit first;
    logic [3:0] a;
    ack_t.delete();
    hi = 0;
    for (int i = 3; i >= 0; i--) begin
      left[i] = mask[i] ? need[i] : 0;
      if (mask[i]) hi = i;
    end
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < left[i]; k++)
        if (i == 0 || i == 3) add_push(i);
        else add_pop(i);
    bif.gnt = op_e'(2'(hi));
    bif.gnt_vld = 1'b1;
    bif.req = mask;
    t0 = cyc;
    n = 0;
    first = 1;
    while (bif.req != 0 && n < 64) begin
      @(negedge DSPCLK);
      n++;
      a = acks();
      for (int i = 0; i < 4; i++)
        if (a[i] && left[i] > 0) begin
          left[i]--;
          if (left[i] == 0) bif.req[i] = 1'b0;
        end
      if (a != 0 && first && bif.gnt_vld) begin
        chk("grant_latency", cyc - t0, 1);
        chk("first_grant", a, 4'b0001 << bif.gnt);
        first = 0;
      end
    end
    if (bif.req != 0) begin
      chk("batch_done", bif.req, 0);
      bif.req = '0;
    end
    bif.gnt_vld = 1'b0;
    repeat (3) @(negedge DSPCLK);
    chk("stk_ovf", STK_OVF, ovf_m);
    chk("stk_unf", STK_UNF, unf_m);
  endtask

  task automatic clear_err();
    ERR_CLR = 1'b1;
    @(negedge DSPCLK);
    ERR_CLR = 1'b0;
    ovf_m = 0;
    unf_m = 0;
    chk("ovf_clr", STK_OVF, 0);
    chk("unf_clr", STK_UNF, 0);
  endtask

  task automatic set_need(input int a, input int b,
                          input int c, input int d);
    need[0] = a;
    need[1] = b;
    need[2] = c;
    need[3] = d;
  endtask

  initial begin
    exp_t e;
    int c0;
    bif.req = '0;
    bif.gnt = OP_IRQ_PUSH;
    bif.gnt_vld = 1'b0;
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    repeat (3) @(negedge DSPCLK);
    chk("rst_acks", acks(), 0);
    chk("rst_push_en", PushST_EN, 0);
    chk("rst_pop_en", PopST_EN, 0);
    chk("rst_rst_vld", RST_VLD, 0);
    chk("rst_ovf", STK_OVF, 0);
    chk("rst_unf", STK_UNF, 0);
    chk("rst_ckenb", STS_CKenb, 1);
    chk("rst_stin", STin, 0);
    chk("rst_fields", {IMASK_R, MSTAT_R, ASTAT_R}, 0);
    T_RST_ = 1'b1;
    @(negedge DSPCLK);

    // Save then restore a known status word.
    ASTAT = 8'hA5;
    MSTAT = 7'h12;
    IMASK = 10'h3C1;
    set_need(1, 0, 0, 0);
    run_batch(4'b0001);
    set_need(0, 1, 0, 0);
    run_batch(4'b0010);

    // All four at once: strict priority order.
    ASTAT = 8'h3C;
    MSTAT = 7'h55;
    IMASK = 10'h2AA;
    set_need(1, 1, 1, 1);
    run_batch(4'b1111);
    clear_err();

    // Held requests are re-served back to back.
    set_need(0, 0, 0, 2);
    run_batch(4'b1000);
    chk("push_b2b_n", ack_t.size(), 2);
    if (ack_t.size() >= 2)
      chk("push_spacing", ack_t[1] - ack_t[0], 2);
    set_need(0, 0, 2, 0);
    run_batch(4'b0100);
    chk("pop_b2b_n", ack_t.size(), 2);
    if (ack_t.size() >= 2)
      chk("pop_spacing", ack_t[1] - ack_t[0], 3);

    // Overflow, then a set coinciding with ERR_CLR.
    set_need(0, 0, 0, DEPTH);
    run_batch(4'b1000);
    clear_err();
    ERR_CLR = 1'b1;
    add_push(3);
    bif.req[3] = 1'b1;
    @(negedge DSPCLK);
    bif.req[3] = 1'b0;
    @(negedge DSPCLK);
    chk("ovf_set_wins", STK_OVF, 1);
    @(negedge DSPCLK);
    chk("ovf_cleared", STK_OVF, 0);
    ERR_CLR = 1'b0;
    ovf_m = 0;

    // Drain past empty: underflow.
    set_need(0, 0, DEPTH + 1, 0);
    run_batch(4'b0100);
    clear_err();

    // A request dropped before grant is ignored.
    c0 = ack_cnt[2];
    add_push(3);
    bif.req[3] = 1'b1;
    @(negedge DSPCLK);
    bif.req[3] = 1'b0;
    bif.req[2] = 1'b1;
    @(negedge DSPCLK);
    bif.req[2] = 1'b0;
    repeat (3) @(negedge DSPCLK);
    chk("dropped_req", ack_cnt[2] - c0, 0);

    // Reset during POP aborts the restore.
    e = '0;
    e.ack = 4'b0010;
    e.po = 1'b1;
    expq.push_back(e);
    bif.req[1] = 1'b1;
    @(negedge DSPCLK);
    bif.req[1] = 1'b0;
    chk("pop_ack_pre_rst", RTI_POP_ACK, 1);
    #1 T_RST_ = 1'b0;
    #1;
    chk("mid_rst_ckenb", STS_CKenb, 1);
    chk("mid_rst_pop_en", PopST_EN, 0);
    chk("mid_rst_acks", acks(), 0);
    @(negedge DSPCLK);
    T_RST_ = 1'b1;
    ovf_m = 0;
    unf_m = 0;
    repeat (4) @(negedge DSPCLK);
    chk("post_rst_ovf", STK_OVF, 0);

    // Randomized batches.
    for (int b = 0; b < 200; b++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++)
        need[i] = m[i] ? int'($urandom_range(1, 2)) : 0;
      ASTAT = 8'($urandom);
      MSTAT = 7'($urandom);
      IMASK = 10'($urandom);
      run_batch(m);
      if ($urandom_range(0, 3) == 0) clear_err();
    end

    repeat (2) @(negedge DSPCLK);
    chk("scoreboard_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
